trace_pipe_tracker: RTL and testbench
=====================================

# trace_pipe_tracker

Carries per-instruction trace fields (instruction word, rd, rs1, rs2, imm) from the decode stage through the EX/MEM/WB pipeline registers of the CPU. Fields stay aligned with stalls, flushes and freezes. At write-back it emits one `trace_valid` strobe per retired instruction, together with the write-back value and a retire count. It sits between the decode stage and the trace logger, and feeds the logger directly.

## Interface
- `DEPTH`, 3: number of stage registers from EX to WB inclusive; legal range 2–8.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `id_valid` input 1: decode holds a real instruction this cycle.
- `id_instruction` input 32: decoded instruction word.
- `id_rd`, `id_rs1`, `id_rs2` input 5 each: register indices.
- `id_imm` input 12 (signed): I-type immediate.
- `stall` input 1: load-use stall; decode is held and a bubble is inserted into EX.
- `flush` input 1: branch taken in EX; the incoming decode entry is killed.
- `freeze` input 1: whole pipeline holds (memory wait).
- `wb_reg_write` input 1: write-back enable from datapath.
- `wb_rd_value` input 32 (signed): write-back data from datapath.
- `trace_valid` output 1: one-cycle retire strobe.
- `trace_instruction` output 32, `trace_rd`/`trace_rs1`/`trace_rs2` output 5, `trace_imm` output 12: WB-stage fields.
- `trace_rd_value` output 32 (signed): reported write-back value.
- `trace_retired` output 32: retired-instruction count.
- `trace_error` output 1: sticky; a write-back occurred with no valid WB entry.

## Operation
- Stage registers `s[0]` (EX) through `s[DEPTH-1]` (WB). Each register holds a valid bit plus all fields.
- Each edge with `rst` low and `freeze` low:
  - `s[k] <= s[k-1]` for k ≥ 1.
  - `s[0]` loads the id fields with valid=1 when `id_valid & ~stall & ~flush`.
  - Otherwise `s[0]` becomes a bubble: valid=0, instruction `32'h00000013`, all other fields 0.
- `freeze` high: every stage holds, and `freeze` overrides `stall` and `flush`.
- `stall` and `flush` together: bubble; the result is the same as either one alone.
- `trace_valid = s[DEPTH-1].valid & ~freeze`. A frozen WB entry is therefore reported once, in the cycle `freeze` drops.
- Field outputs are driven combinationally from `s[DEPTH-1]`.
- `trace_rd_value`:
  - `wb_rd_value` when `trace_valid & wb_reg_write & (trace_rd != 0)`.
  - 0 otherwise; x0 always reports 0.
- `trace_retired` increments by 1 on each edge where `trace_valid` is high, and wraps from `32'hFFFFFFFF` to 0.
- `trace_error` is set on any edge with `wb_reg_write & ~s[DEPTH-1].valid & ~freeze`. It is cleared only by `rst`.

## Timing
- Reset values:
  - All stage valids = 0, fields = bubble.
  - `trace_valid` 0, `trace_instruction` `32'h00000013`, `trace_rd`/`trace_rs1`/`trace_rs2`/`trace_imm` 0, `trace_rd_value` 0.
  - `trace_retired` 0, `trace_error` 0.
- Latency: an entry accepted at edge N drives `trace_valid` high in the cycle after edge N+DEPTH−1, i.e. DEPTH edges after capture, plus one extra cycle per frozen cycle.
- Throughput: one retire per cycle maximum.
- `rst` asserted mid-operation discards all in-flight entries; no strobe is produced for them.
- `rst` wins over `freeze`, `stall` and `flush`.
- `wb_rd_value` is sampled in the same cycle as `trace_valid`, which matches the datapath WB timing.

## Configuration
- `TRACE_RETIRE_CNT_EN` defined: the `trace_retired` counter and its increment logic are built.
- Not defined: `trace_retired` is tied to 0 and no counter flops are synthesized. All other behaviour is unchanged, and the port list stays identical.

## Structure
- Package `trace_pkg`:
  - `trace_entry_t` struct: valid, instruction, rd, rs1, rs2, imm.
  - `TRACE_NOP = 32'h00000013`.
  - `TRACE_BUBBLE` constant entry.
  - Default `DEPTH`.
- Sub-module `trace_stage_reg`: one entry register with load/hold/reset. It is instantiated DEPTH times in a generate loop.

## Test plan
- Reset, then `id_valid` with instruction `32'h00500093` (rd=1, imm=5), `wb_reg_write`=1, `wb_rd_value`=5 → `trace_valid` fires exactly once, 3 edges later; fields match; `trace_rd_value`=5; `trace_retired`=1.
- `stall` high for one cycle between two instructions → one bubble, two strobes separated by one idle cycle; `trace_retired`=2.
- `flush` and `stall` both high on a decode entry → that entry is never reported; neighbouring entries are reported in order.
- `freeze` held 4 cycles while WB is valid → `trace_valid` stays low for those cycles and pulses once after release; the count increments once.
- Write to x0 with `wb_rd_value=32'hDEADBEEF` → `trace_rd_value`=0. Separately, `wb_reg_write`=1 on a bubble → `trace_error`=1, which persists until `rst`.
- Preload `trace_retired` near wrap by running 2^32−1 retires (forced), then one more retire → count reads 0. Build without `TRACE_RETIRE_CNT_EN` → the count stays 0.

Source files
------------

// File: rtl/trace_pipe_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Brief    : Shared types and constants for the trace pipeline tracker:
//            the per-stage trace entry, the NOP word used for bubbles,
//            the bubble entry itself and the default pipeline depth.
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // Stage registers from EX to WB inclusive.
    localparam int TRACE_DEPTH_DEFAULT = 3;

    // addi x0, x0, 0 - the canonical RISC-V NOP shown for empty slots.
    localparam logic [31:0] TRACE_NOP = 32'h00000013;

    typedef struct packed {
        logic               valid;
        logic [31:0]        instruction;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic signed [11:0] imm;
    } trace_entry_t;

    localparam trace_entry_t TRACE_BUBBLE = '{
        valid:       1'b0,
        instruction: TRACE_NOP,
        rd:          5'd0,
        rs1:         5'd0,
        rs2:         5'd0,
        imm:         12'sd0
    };

    // Builds the entry entering EX: the decode fields when accepted,
    // otherwise a bubble so no stale field leaks into the trace.
    function automatic trace_entry_t trace_capture(
        input logic               accept,
        input logic [31:0]        instruction,
        input logic [4:0]         rd,
        input logic [4:0]         rs1,
        input logic [4:0]         rs2,
        input logic signed [11:0] imm
    );
        trace_entry_t e;
        e = TRACE_BUBBLE;
        if (accept) begin
            e.valid       = 1'b1;
            e.instruction = instruction;
            e.rd          = rd;
            e.rs1         = rs1;
            e.rs2         = rs2;
            e.imm         = imm;
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_pipe_tracker_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : trace_stage_reg
// Brief    : One trace pipeline slot. Resets to the bubble entry, loads the
//            upstream entry when enabled and holds it otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module trace_stage_reg
    import trace_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  trace_entry_t d,
    output trace_entry_t q
);

    trace_entry_t r_entry;

    // Slot register: reset to bubble, advance on load, hold while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry <= TRACE_BUBBLE;
        end else if (load) begin
            r_entry <= d;
        end
    end

    assign q = r_entry;

endmodule
`default_nettype wire

// File: rtl/trace_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module   : trace_pipe_tracker
// Brief    : Carries decode-stage trace fields down the EX..WB pipeline in
//            lock-step with stalls, flushes and freezes, and emits one
//            retire strobe per instruction at write-back together with the
//            write-back value, a retire count and a sticky error flag.
//            Build option TRACE_RETIRE_CNT_EN: when defined the retire
//            counter is built; otherwise trace_retired is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module trace_pipe_tracker
    import trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [31:0]        id_instruction,
    input  logic [4:0]         id_rd,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic signed [11:0] id_imm,
    input  logic               stall,
    input  logic               flush,
    input  logic               freeze,
    input  logic               wb_reg_write,
    input  logic signed [31:0] wb_rd_value,
    output logic               trace_valid,
    output logic [31:0]        trace_instruction,
    output logic [4:0]         trace_rd,
    output logic [4:0]         trace_rs1,
    output logic [4:0]         trace_rs2,
    output logic signed [11:0] trace_imm,
    output logic signed [31:0] trace_rd_value,
    output logic [31:0]        trace_retired,
    output logic               trace_error
);

    trace_entry_t               w_id_entry;
    trace_entry_t [DEPTH-1:0]   w_stage_d;
    trace_entry_t [DEPTH-1:0]   w_stage_q;
    trace_entry_t               w_wb;
    logic                       w_advance;
    logic                       r_error;

    // Freeze holds every slot; stall/flush only turn the EX input into a bubble.
    assign w_advance  = ~freeze;
    assign w_id_entry = trace_capture(id_valid & ~stall & ~flush, id_instruction,
                                      id_rd, id_rs1, id_rs2, id_imm);

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_stage_d[k] = w_id_entry;
            end else begin : g_chain
                assign w_stage_d[k] = w_stage_q[k-1];
            end

            trace_stage_reg u_stage (
                .clk  (clk),
                .rst  (rst),
                .load (w_advance),
                .d    (w_stage_d[k]),
                .q    (w_stage_q[k])
            );
        end
    endgenerate

    assign w_wb = w_stage_q[DEPTH-1];

    // A frozen WB entry is reported once, in the cycle the freeze drops.
    assign trace_valid       = w_wb.valid & ~freeze;
    assign trace_instruction = w_wb.instruction;
    assign trace_rd          = w_wb.rd;
    assign trace_rs1         = w_wb.rs1;
    assign trace_rs2         = w_wb.rs2;
    assign trace_imm         = w_wb.imm;

    // x0 never holds a value, so writes to it report zero.
    assign trace_rd_value = (trace_valid && wb_reg_write && (w_wb.rd != 5'd0))
                            ? wb_rd_value : 32'sd0;

    // Sticky flag: a register write arrived with no instruction at WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (wb_reg_write && !w_wb.valid && !freeze) begin
            r_error <= 1'b1;
        end
    end

    assign trace_error = r_error;

`ifdef TRACE_RETIRE_CNT_EN
    logic [31:0] r_retired;

    // Retire counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= 32'd0;
        end else if (trace_valid) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign trace_retired = r_retired;
`else
    assign trace_retired = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trace_pipe_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_pipe_tracker
// Brief    : Self-checking bench for trace_pipe_tracker (DEPTH=3): a
//            cycle-by-cycle vector table plus short hand-written sequences
//            for reset-in-flight, single-retire latency and counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_pipe_tracker;

`ifdef TRACE_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int NROWS = 33;

    logic               clk = 1'b0;
    logic               rst;
    logic               id_valid;
    logic [31:0]        id_instruction;
    logic [4:0]         id_rd, id_rs1, id_rs2;
    logic signed [11:0] id_imm;
    logic               stall, flush, freeze;
    logic               wb_reg_write;
    logic signed [31:0] wb_rd_value;
    logic               trace_valid;
    logic [31:0]        trace_instruction;
    logic [4:0]         trace_rd, trace_rs1, trace_rs2;
    logic signed [11:0] trace_imm;
    logic signed [31:0] trace_rd_value;
    logic [31:0]        trace_retired;
    logic               trace_error;

    trace_pipe_tracker #(.DEPTH(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_valid          (id_valid),
        .id_instruction    (id_instruction),
        .id_rd             (id_rd),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_imm            (id_imm),
        .stall             (stall),
        .flush             (flush),
        .freeze            (freeze),
        .wb_reg_write      (wb_reg_write),
        .wb_rd_value       (wb_rd_value),
        .trace_valid       (trace_valid),
        .trace_instruction (trace_instruction),
        .trace_rd          (trace_rd),
        .trace_rs1         (trace_rs1),
        .trace_rs2         (trace_rs2),
        .trace_imm         (trace_imm),
        .trace_rd_value    (trace_rd_value),
        .trace_retired     (trace_retired),
        .trace_error       (trace_error)
    );

    always #5 clk = ~clk;

    // Instruction catalogue: index 0 is the bubble view (NOP, zero fields).
    logic [31:0] ins_w  [6];
    logic [4:0]  ins_rd [6];
    logic [4:0]  ins_rs1[6];
    logic [4:0]  ins_rs2[6];
    logic [11:0] ins_imm[6];

    typedef struct {
        int          id;     // instruction presented at decode (0 = none)
        bit          st;
        bit          fl;
        bit          fz;
        bit          wbw;
        logic [31:0] wbv;
        int          ex;     // instruction expected at WB (0 = bubble)
        bit          etv;
        logic [31:0] erdv;
        bit          eerr;
    } vec_t;

    vec_t vecs[NROWS];
    int   checks   = 0;
    int   failures = 0;
    int   exp_ret  = 0;

    function automatic vec_t mk(int id, bit st, bit fl, bit fz, bit wbw,
                                logic [31:0] wbv, int ex, bit etv,
                                logic [31:0] erdv, bit eerr);
        vec_t v;
        v.id = id; v.st = st; v.fl = fl; v.fz = fz; v.wbw = wbw; v.wbv = wbv;
        v.ex = ex; v.etv = etv; v.erdv = erdv; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int id, input bit st, input bit fl, input bit fz,
                         input bit wbw, input logic [31:0] wbv);
        id_valid       = (id != 0);
        id_instruction = (id != 0) ? ins_w[id]   : 32'h0;
        id_rd          = (id != 0) ? ins_rd[id]  : 5'd0;
        id_rs1         = (id != 0) ? ins_rs1[id] : 5'd0;
        id_rs2         = (id != 0) ? ins_rs2[id] : 5'd0;
        id_imm         = (id != 0) ? ins_imm[id] : 12'd0;
        stall          = st;
        flush          = fl;
        freeze         = fz;
        wb_reg_write   = wbw;
        wb_rd_value    = wbv;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, trace_valid}, 32'd0);
        chk({tag, "_instr"}, trace_instruction, 32'h00000013);
        chk({tag, "_fields"}, {17'd0, trace_rd, trace_rs1, trace_rs2, trace_imm}, 32'd0);
        chk({tag, "_rdval"}, trace_rd_value, 32'd0);
        chk({tag, "_retired"}, trace_retired, 32'd0);
        chk({tag, "_error"}, {31'd0, trace_error}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        int strobes;
        int strobe_row;

        // A: addi x1,x0,5   B: addi x2,x0,10   C: add x3,x1,x2
        // D: addi x0,x0,255 E: addi x4,x1,-1
        ins_w[0] = 32'h00000013; ins_rd[0] = 5'd0; ins_rs1[0] = 5'd0; ins_rs2[0] = 5'd0; ins_imm[0] = 12'h000;
        ins_w[1] = 32'h00500093; ins_rd[1] = 5'd1; ins_rs1[1] = 5'd0; ins_rs2[1] = 5'd0; ins_imm[1] = 12'h005;
        ins_w[2] = 32'h00a00113; ins_rd[2] = 5'd2; ins_rs1[2] = 5'd0; ins_rs2[2] = 5'd0; ins_imm[2] = 12'h00a;
        ins_w[3] = 32'h002081b3; ins_rd[3] = 5'd3; ins_rs1[3] = 5'd1; ins_rs2[3] = 5'd2; ins_imm[3] = 12'h000;
        ins_w[4] = 32'h0ff00013; ins_rd[4] = 5'd0; ins_rs1[4] = 5'd0; ins_rs2[4] = 5'd0; ins_imm[4] = 12'h0ff;
        ins_w[5] = 32'hfff08213; ins_rd[5] = 5'd4; ins_rs1[5] = 5'd1; ins_rs2[5] = 5'd0; ins_imm[5] = 12'hfff;

        //            id st fl fz wbw wbv           ex tv erdv          err
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[3]  = mk(0, 0, 0, 0, 1, 32'd5,         1, 1, 32'd5,        0);
        vecs[4]  = mk(2, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[5]  = mk(3, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);  // stall
        vecs[6]  = mk(3, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'd10,        2, 1, 32'd10,       0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);  // stall bubble
        vecs[9]  = mk(0, 0, 0, 0, 1, 32'd15,        3, 1, 32'd15,       0);
        vecs[10] = mk(1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[11] = mk(2, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,        0);  // stall+flush
        vecs[12] = mk(3, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[13] = mk(0, 0, 0, 0, 1, 32'd5,         1, 1, 32'd5,        0);
        vecs[14] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[15] = mk(0, 0, 0, 0, 0, 32'h0,         3, 1, 32'h0,        0);  // no write-back
        vecs[16] = mk(5, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[17] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[18] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[19] = mk(0, 0, 0, 1, 1, 32'd7,         5, 0, 32'h0,        0);  // freeze x4
        vecs[20] = mk(1, 1, 1, 1, 1, 32'd7,         5, 0, 32'h0,        0);
        vecs[21] = mk(1, 0, 0, 1, 1, 32'd7,         5, 0, 32'h0,        0);
        vecs[22] = mk(0, 0, 0, 1, 0, 32'h0,         5, 0, 32'h0,        0);
        vecs[23] = mk(0, 0, 0, 0, 1, 32'hffffffff,  5, 1, 32'hffffffff, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[25] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[26] = mk(4, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[27] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[28] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        0);
        vecs[29] = mk(0, 0, 0, 0, 1, 32'hdeadbeef,  4, 1, 32'h0,        0);  // x0
        vecs[30] = mk(0, 0, 0, 0, 1, 32'd1,         0, 0, 32'h0,        0);  // write on bubble
        vecs[31] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        1);
        vecs[32] = mk(0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,        1);

        // Reset state
        do_reset();
        chk_idle_outputs("reset");

        // Vector table: drive at negedge, compare 1 time unit later
        for (int i = 0; i < NROWS; i++) begin
            drive(vecs[i].id, vecs[i].st, vecs[i].fl, vecs[i].fz, vecs[i].wbw, vecs[i].wbv);
            #1;
            chk($sformatf("r%0d_valid", i), {31'd0, trace_valid}, {31'd0, vecs[i].etv});
            chk($sformatf("r%0d_instr", i), trace_instruction, ins_w[vecs[i].ex]);
            chk($sformatf("r%0d_rd", i),  {27'd0, trace_rd},  {27'd0, ins_rd[vecs[i].ex]});
            chk($sformatf("r%0d_rs1", i), {27'd0, trace_rs1}, {27'd0, ins_rs1[vecs[i].ex]});
            chk($sformatf("r%0d_rs2", i), {27'd0, trace_rs2}, {27'd0, ins_rs2[vecs[i].ex]});
            chk($sformatf("r%0d_imm", i), {20'd0, trace_imm}, {20'd0, ins_imm[vecs[i].ex]});
            chk($sformatf("r%0d_rdval", i), trace_rd_value, vecs[i].erdv);
            chk($sformatf("r%0d_error", i), {31'd0, trace_error}, {31'd0, vecs[i].eerr});
            chk($sformatf("r%0d_retired", i), trace_retired, CNT_EN ? exp_ret : 0);
            if (vecs[i].etv) exp_ret++;
            @(negedge clk);
        end

        // Reset with two entries in flight: both discarded, error cleared
        drive(1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        drive(2, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 32'h0);   // freeze must not block reset
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h0);
        #1;
        chk_idle_outputs("midrst");
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("midrst_c%0d_valid", j), {31'd0, trace_valid}, 32'd0);
        end
        @(negedge clk);

        // Single retire: one strobe exactly three edges after capture
        strobes    = 0;
        strobe_row = -1;
        for (int r = 0; r < 7; r++) begin
            drive((r == 0) ? 1 : 0, 0, 0, 0, (r == 3), 32'd5);
            #1;
            if (trace_valid) begin
                strobes++;
                strobe_row = r;
                chk("single_rdval", trace_rd_value, 32'd5);
                chk("single_instr", trace_instruction, 32'h00500093);
            end
            @(negedge clk);
        end
        chk("single_strobes", strobes, 32'd1);
        chk("single_latency", strobe_row, 32'd3);
        chk("single_retired", trace_retired, CNT_EN ? 32'd1 : 32'd0);
        chk("single_error", {31'd0, trace_error}, 32'd0);

`ifdef TRACE_RETIRE_CNT_EN
        // Counter wrap: preload all-ones, then one more retire reads zero
        force dut.r_retired = 32'hffffffff;
        #1;
        release dut.r_retired;
        @(negedge clk);
        chk("wrap_preload", trace_retired, 32'hffffffff);
        for (int r = 0; r < 4; r++) begin
            drive((r == 0) ? 1 : 0, 0, 0, 0, (r == 3), 32'd5);
            @(negedge clk);
        end
        #1;
        chk("wrap_zero", trace_retired, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
